alu_cmd_sequencer: RTL

//   Drives the 4-bit ALU. Accepts one command per handshake on a valid/ready port.

---
 rtl/alu_cmd_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a combinational 4-bit ALU. It accepts one command at a time,
// holds the ALU inputs for SETTLE_CYCLES edges, captures f into the accumulator and returns it.
module alu_cmd_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    input  logic [WIDTH-1:0] alu_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [2:0]         r_alu_s;
    logic               r_cmd_ready;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_data;
    logic               r_res_zero;
    logic               w_cmd_fire;
    logic               w_res_fire;
    logic               w_settle_done;

    assign w_cmd_fire    = cmd_valid && r_cmd_ready;
    assign w_res_fire    = r_res_valid && res_ready;
    assign w_settle_done = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_s     <= '0;
            r_cmd_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_load) begin
                            r_acc       <= cmd_data;
                            r_res_data  <= cmd_data;
                            r_res_zero  <= (cmd_data == '0);
                            r_res_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            // Snapshot acc so the ALU sees a stable a while f settles.
                            r_alu_a <= r_acc;
                            r_alu_b <= cmd_data;
                            r_alu_s <= cmd_op;
                            r_cnt   <= CNT_W'(SETTLE_CYCLES);
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_settle_done) begin
                        r_acc       <= alu_f;
                        r_res_data  <= alu_f;
                        r_res_zero  <= (alu_f == '0);
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_res_fire) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_zero  = r_res_zero;
    assign acc       = r_acc;

endmodule
